// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch unit: instruction field layout, opcodes,
// reset PC default, fetch FSM state encoding and the branch-offset helper.
// No logic of its own; imported by fetch_unit and next_pc_calc.
package fetch_unit_pkg;

    // Instruction field bit positions
    localparam int OPCODE_HI = 31;
    localparam int OPCODE_LO = 28;
    localparam int RD_HI     = 27;
    localparam int RD_LO     = 24;
    localparam int RS_HI     = 23;
    localparam int RS_LO     = 20;
    localparam int RT_HI     = 19;
    localparam int RT_LO     = 16;
    localparam int IMM_HI    = 15;
    localparam int IMM_LO    = 0;

    // Opcode map
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_J    = 4'b1100;
    localparam logic [3:0] OP_JR   = 4'b1101;
    localparam logic [3:0] OP_LW   = 4'b1110;
    localparam logic [3:0] OP_SW   = 4'b1111;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } fetch_state_t;

    // Word-offset immediate turned into a signed byte offset
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Next-PC selection: sequential, register-indirect jump or PC-relative branch.
// Purely combinational, zero cycles.
// No flow control; the caller decides when to load the result.
module next_pc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [15:0] imm,
    input  logic [31:0] rs_data,
    input  logic        take_branch,
    input  logic        jump_sel,
    output logic [31:0] next_pc
);

    logic [31:0] pc_seq;

    assign pc_seq = pc + 32'd4;

    // Pick the target; all adds wrap naturally at 32 bits
    always_comb begin
        next_pc = pc_seq;
        if (take_branch) begin
            if (jump_sel) begin
                next_pc = rs_data;
            end else begin
                next_pc = pc_seq + branch_offset(imm);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, single-outstanding fetch FSM, field decode.
// Fetch latency is 1 cycle plus memory wait cycles; PC updates take effect next edge.
// No queueing: fetch requests while busy are dropped; memory stalls via mem_ready.
// Optional macro FETCH_ALIGN_CHECK_EN adds a sticky align_fault output.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_flag,
    input  logic        instruction_flag,
    input  logic        take_branch,
    input  logic        jump_sel,
    input  logic [31:0] rs_data,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic [31:0] instr,
    output logic [3:0]  opcode,
    output logic [3:0]  rd,
    output logic [3:0]  rs,
    output logic [3:0]  rt,
    output logic [15:0] imm,
    output logic        fetch_busy,
    output logic [31:0] retired
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        align_fault
`endif
);

    fetch_state_t state;
    logic [31:0]  next_pc;

    next_pc_calc u_next_pc (
        .pc          (pc),
        .imm         (imm),
        .rs_data     (rs_data),
        .take_branch (take_branch),
        .jump_sel    (jump_sel),
        .next_pc     (next_pc)
    );

    // Decoded fields follow the held instruction register
    assign opcode = instr[OPCODE_HI:OPCODE_LO];
    assign rd     = instr[RD_HI:RD_LO];
    assign rs     = instr[RS_HI:RS_LO];
    assign rt     = instr[RT_HI:RT_LO];
    assign imm    = instr[IMM_HI:IMM_LO];

    // PC register; independent of the fetch FSM so updates land even mid-fetch
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc <= RESET_PC;
`ifdef FETCH_ALIGN_CHECK_EN
            align_fault <= 1'b0;
`endif
        end else if (pc_flag) begin
`ifdef FETCH_ALIGN_CHECK_EN
            if (next_pc[1:0] != 2'b00) begin
                align_fault <= 1'b1;
            end else begin
                pc <= next_pc;
            end
`else
            pc <= next_pc;
`endif
        end
    end

    // Fetch FSM: address captured at request so later PC moves don't disturb it
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            mem_rd     <= 1'b0;
            fetch_busy <= 1'b0;
            mem_addr   <= RESET_PC;
            instr      <= 32'h0;
            retired    <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instruction_flag) begin
                        state      <= ST_WAIT;
                        mem_rd     <= 1'b1;
                        fetch_busy <= 1'b1;
                        mem_addr   <= pc;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        state      <= ST_IDLE;
                        mem_rd     <= 1'b0;
                        fetch_busy <= 1'b0;
                        instr      <= mem_rdata;
                        retired    <= retired + 32'd1;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    mem_rd     <= 1'b0;
                    fetch_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit with PC and fetch scoreboards.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        pc_flag;
    logic        instruction_flag;
    logic        take_branch;
    logic        jump_sel;
    logic [31:0] rs_data;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] pc;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] instr;
    logic [3:0]  opcode;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] imm;
    logic        fetch_busy;
    logic [31:0] retired;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        align_fault;
`endif

    fetch_unit dut (
        .clk              (clk),
        .reset            (reset),
        .pc_flag          (pc_flag),
        .instruction_flag (instruction_flag),
        .take_branch      (take_branch),
        .jump_sel         (jump_sel),
        .rs_data          (rs_data),
        .mem_rdata        (mem_rdata),
        .mem_ready        (mem_ready),
        .pc               (pc),
        .mem_addr         (mem_addr),
        .mem_rd           (mem_rd),
        .instr            (instr),
        .opcode           (opcode),
        .rd               (rd),
        .rs               (rs),
        .rt               (rt),
        .imm              (imm),
        .fetch_busy       (fetch_busy),
        .retired          (retired)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .align_fault      (align_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] pc_q[$];
    logic [31:0] fetch_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [31:0] exp_ret;
    logic [31:0] exp_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [15:0] im,
                                               input logic [31:0] rsv, input bit br, input bit js);
        logic [31:0] off;
        off = {{16{im[15]}}, im} * 32'd4;
        if (!br) return p + 32'd4;
        if (js) return rsv;
        return p + 32'd4 + off;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        step();
        reset = 1'b1;
        exp_pc    = 32'h0;
        exp_instr = 32'h0;
        exp_ret   = 32'h0;
        exp_addr  = 32'h0;
        pc_q.delete();
        fetch_q.delete();
    endtask

    // One PC strobe; expected PC pushed at drive time, popped after the edge
    task automatic pc_strobe(input string tag, input bit br, input bit js, input logic [31:0] rsv);
        logic [31:0] tgt;
        take_branch = br;
        jump_sel    = js;
        rs_data     = rsv;
        pc_flag     = 1'b1;
        tgt = model_next(exp_pc, exp_instr[15:0], rsv, br, js);
`ifdef FETCH_ALIGN_CHECK_EN
        if (tgt[1:0] == 2'b00) exp_pc = tgt;
`else
        exp_pc = tgt;
`endif
        pc_q.push_back(exp_pc);
        step();
        pc_flag     = 1'b0;
        take_branch = 1'b0;
        jump_sel    = 1'b0;
        chk(tag, pc, pc_q.pop_front());
    endtask

    // Fetch with mem_ready on the ready_at-th busy cycle; optional poke of
    // instruction_flag while busy and sequential PC strobes mid-wait and at completion
    task automatic do_fetch(input logic [31:0] word, input int ready_at, input bit poke, input bit pc_mid);
        int  busy;
        bit  done;
        mem_rdata        = word;
        instruction_flag = 1'b1;
        fetch_q.push_back(word);
        exp_addr = exp_pc;
        step();
        instruction_flag = 1'b0;
        chk("mem_rd_req", {31'b0, mem_rd}, 32'd1);
        busy = 0;
        done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (fetch_busy) busy++;
            if (poke && busy == 1) instruction_flag = 1'b1;
            mem_ready = (busy == ready_at);
            if (pc_mid && (busy == 1 || busy == ready_at)) begin
                pc_flag = 1'b1;
                exp_pc  = exp_pc + 32'd4;
            end
            step();
            mem_ready        = 1'b0;
            instruction_flag = 1'b0;
            pc_flag          = 1'b0;
            if (!fetch_busy) done = 1'b1;
        end
        chk("fetch_done", {31'b0, fetch_busy}, 32'd0);
        chk("busy_cycles", busy, ready_at);
        exp_instr = fetch_q.pop_front();
        exp_ret   = exp_ret + 32'd1;
        chk("instr", instr, exp_instr);
        chk("opcode", {28'b0, opcode}, {28'b0, exp_instr[31:28]});
        chk("rd", {28'b0, rd}, {28'b0, exp_instr[27:24]});
        chk("rs", {28'b0, rs}, {28'b0, exp_instr[23:20]});
        chk("rt", {28'b0, rt}, {28'b0, exp_instr[19:16]});
        chk("imm", {16'b0, imm}, {16'b0, exp_instr[15:0]});
        chk("retired", retired, exp_ret);
        chk("mem_addr", mem_addr, exp_addr);
        if (pc_mid) chk("pc_during_fetch", pc, exp_pc);
        if (poke) begin
            step();
            chk("no_queue", {31'b0, fetch_busy}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset            = 1'b1;
        pc_flag          = 1'b0;
        instruction_flag = 1'b0;
        take_branch      = 1'b0;
        jump_sel         = 1'b0;
        rs_data          = 32'h0;
        mem_rdata        = 32'h0;
        mem_ready        = 1'b0;
        step();
        do_reset();

        chk("rst_pc", pc, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("rst_busy", {31'b0, fetch_busy}, 32'd0);
        chk("rst_retired", retired, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("rst_fault", {31'b0, align_fault}, 32'd0);
`endif

        for (int i = 0; i < 3; i++) pc_strobe("pc_seq", 1'b0, 1'b0, 32'h0);

        do_fetch(32'h4123_0005, 3, 1'b0, 1'b0);

        // mem_ready while idle must not load anything
        mem_rdata = 32'hFFFF_FFFF;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("idle_ready_instr", instr, exp_instr);
        chk("idle_ready_retired", retired, exp_ret);
        chk("idle_ready_busy", {31'b0, fetch_busy}, 32'd0);

        pc_strobe("jump_100", 1'b1, 1'b1, 32'h0000_0100);
        do_fetch(32'hA000_FFFE, 1, 1'b0, 1'b0);
        pc_strobe("branch_back", 1'b1, 1'b0, 32'h0);
        pc_strobe("jump_2000", 1'b1, 1'b1, 32'h0000_2000);

        do_fetch(32'h7654_3210, 4, 1'b1, 1'b1);

        pc_strobe("jump_top", 1'b1, 1'b1, 32'hFFFF_FFFC);
        pc_strobe("pc_wrap", 1'b0, 1'b0, 32'h0);
        pc_strobe("branch_fwd", 1'b1, 1'b0, 32'h0);

        // Reset during WAIT abandons the fetch
        instruction_flag = 1'b1;
        step();
        instruction_flag = 1'b0;
        chk("abandon_busy_pre", {31'b0, fetch_busy}, 32'd1);
        do_reset();
        mem_rdata = 32'hDEAD_BEEF;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("abandon_instr", instr, 32'h0);
        chk("abandon_retired", retired, 32'h0);
        chk("abandon_busy", {31'b0, fetch_busy}, 32'd0);
        chk("abandon_mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("abandon_pc", pc, 32'h0);

`ifdef FETCH_ALIGN_CHECK_EN
        pc_strobe("jump_2000b", 1'b1, 1'b1, 32'h0000_2000);
        pc_strobe("misaligned_hold", 1'b1, 1'b1, 32'h0000_2002);
        chk("fault_set", {31'b0, align_fault}, 32'd1);
        pc_strobe("seq_after_fault", 1'b0, 1'b0, 32'h0);
        chk("fault_sticky", {31'b0, align_fault}, 32'd1);
        do_reset();
        chk("fault_cleared", {31'b0, align_fault}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
